// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the shared data-memory port.
// One transaction in flight: issue, memory acknowledge, response back to the owner; a watchdog traps a hung memory.
module dmem_arbiter #(
  parameter int addr_width_p     = 12,
  parameter int timeout_cycles_p = 64
) (
  input  logic                         clk,
  input  logic                         n_reset,
  input  logic [1:0]                   req_valid_i,
  input  logic [1:0][addr_width_p-1:0] req_addr_i,
  input  logic [1:0][31:0]             req_wdata_i,
  input  logic [1:0]                   req_wen_i,
  input  logic [1:0]                   req_byte_i,
  output logic [1:0]                   req_yumi_o,
  output logic [1:0]                   resp_valid_o,
  output logic [31:0]                  resp_data_o,
  input  logic [1:0]                   resp_yumi_i,
  output logic                         mem_valid_o,
  output logic [addr_width_p-1:0]      mem_addr_o,
  output logic [31:0]                  mem_wdata_o,
  output logic                         mem_wen_o,
  output logic                         mem_byte_o,
  input  logic                         mem_yumi_i,
  input  logic                         mem_rvalid_i,
  input  logic [31:0]                  mem_rdata_i,
  output logic                         mem_ryumi_o,
  output logic                         owner_o,
  output logic                         err_o
);

  localparam logic [1:0] DMEM_IDLE      = 2'd0;
  localparam logic [1:0] DMEM_REQ_SENT  = 2'd1;
  localparam logic [1:0] DMEM_REQ_ACKED = 2'd2;
  localparam logic [1:0] ERR            = 2'd3;
  localparam logic [7:0] TIMEOUT_C      = 8'(timeout_cycles_p);

  logic [1:0]              r_state;
  logic                    r_owner;
  logic                    r_last_grant;
  logic [addr_width_p-1:0] r_addr;
  logic [31:0]             r_wdata;
  logic                    r_wen;
  logic                    r_byte;
  logic [7:0]              r_wdog;

  logic [1:0]              w_state_nxt;
  logic [7:0]              w_wdog_nxt;
  logic [7:0]              w_wdog_inc;
  logic                    w_grant;
  logic                    w_take;

  assign w_wdog_inc = r_wdog + 8'd1;
  assign w_take     = (r_state == DMEM_IDLE) && (|req_valid_i);

  // Grant selection: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    w_grant = 1'b0;
    if (&req_valid_i) begin
      w_grant = ~r_last_grant;
    end else begin
      w_grant = req_valid_i[1];
    end
  end

  // Next-state and watchdog update.
  always_comb begin
    w_state_nxt = r_state;
    w_wdog_nxt  = r_wdog;
    case (r_state)
      DMEM_IDLE: begin
        if (|req_valid_i) begin
          w_state_nxt = DMEM_REQ_SENT;
        end else begin
          w_state_nxt = DMEM_IDLE;
        end
      end
      DMEM_REQ_SENT: begin
        if (mem_yumi_i) begin
          w_state_nxt = DMEM_REQ_ACKED;
          w_wdog_nxt  = 8'd0;
        end else begin
          w_state_nxt = DMEM_REQ_SENT;
        end
      end
      DMEM_REQ_ACKED: begin
        // Counter freezes while a response is presented so owner backpressure never times out.
        if (mem_rvalid_i) begin
          if (resp_yumi_i[r_owner]) begin
            w_state_nxt = DMEM_IDLE;
          end else begin
            w_state_nxt = DMEM_REQ_ACKED;
          end
        end else begin
          w_wdog_nxt = w_wdog_inc;
          if (w_wdog_inc == TIMEOUT_C) begin
            w_state_nxt = ERR;
          end else begin
            w_state_nxt = DMEM_REQ_ACKED;
          end
        end
      end
      ERR: begin
        w_state_nxt = ERR;
      end
      default: begin
        w_state_nxt = DMEM_IDLE;
      end
    endcase
  end

  // State, watchdog and latched command registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state      <= DMEM_IDLE;
      r_wdog       <= 8'd0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_addr       <= '0;
      r_wdata      <= 32'd0;
      r_wen        <= 1'b0;
      r_byte       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wdog  <= w_wdog_nxt;
      if (w_take) begin
        r_owner      <= w_grant;
        r_last_grant <= w_grant;
        r_addr       <= req_addr_i[w_grant];
        r_wdata      <= req_wdata_i[w_grant];
        r_wen        <= req_wen_i[w_grant];
        r_byte       <= req_byte_i[w_grant];
      end
    end
  end

  // Handshake steering toward the owning port; everything quiet outside the active states.
  always_comb begin
    req_yumi_o   = 2'b00;
    resp_valid_o = 2'b00;
    resp_data_o  = 32'd0;
    mem_ryumi_o  = 1'b0;
    case (r_state)
      DMEM_REQ_SENT: begin
        req_yumi_o[r_owner] = mem_yumi_i;
      end
      DMEM_REQ_ACKED: begin
        resp_valid_o[r_owner] = mem_rvalid_i;
        resp_data_o           = mem_rdata_i;
        mem_ryumi_o           = resp_yumi_i[r_owner];
      end
      default: begin
        req_yumi_o   = 2'b00;
        resp_valid_o = 2'b00;
        resp_data_o  = 32'd0;
        mem_ryumi_o  = 1'b0;
      end
    endcase
  end

  assign mem_valid_o = (r_state == DMEM_REQ_SENT);
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign mem_wen_o   = r_wen;
  assign mem_byte_o  = r_byte;
  assign owner_o     = r_owner;
  assign err_o       = (r_state == ERR);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: two instances share stimulus, one with a 4-cycle and one with a 16-cycle watchdog.
module tb_dmem_arbiter;

  logic              clk;
  logic              n_reset;
  logic [1:0]        req_valid;
  logic [1:0][11:0]  req_addr;
  logic [1:0][31:0]  req_wdata;
  logic [1:0]        req_wen;
  logic [1:0]        req_byte;
  logic [1:0]        resp_yumi;
  logic              mem_yumi;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  logic [1:0]  a_req_yumi, a_resp_valid, b_req_yumi, b_resp_valid;
  logic [31:0] a_resp_data, a_mem_wdata, b_resp_data, b_mem_wdata;
  logic [11:0] a_mem_addr, b_mem_addr;
  logic        a_mem_valid, a_mem_wen, a_mem_byte, a_mem_ryumi, a_owner, a_err;
  logic        b_mem_valid, b_mem_wen, b_mem_byte, b_mem_ryumi, b_owner, b_err;

  int n_vec;
  int n_bad;

  dmem_arbiter #(.addr_width_p(12), .timeout_cycles_p(4)) u_dut_a (
    .clk(clk), .n_reset(n_reset),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_wen_i(req_wen), .req_byte_i(req_byte), .req_yumi_o(a_req_yumi),
    .resp_valid_o(a_resp_valid), .resp_data_o(a_resp_data), .resp_yumi_i(resp_yumi),
    .mem_valid_o(a_mem_valid), .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata),
    .mem_wen_o(a_mem_wen), .mem_byte_o(a_mem_byte), .mem_yumi_i(mem_yumi),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_ryumi_o(a_mem_ryumi),
    .owner_o(a_owner), .err_o(a_err)
  );

  dmem_arbiter #(.addr_width_p(12), .timeout_cycles_p(16)) u_dut_b (
    .clk(clk), .n_reset(n_reset),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_wen_i(req_wen), .req_byte_i(req_byte), .req_yumi_o(b_req_yumi),
    .resp_valid_o(b_resp_valid), .resp_data_o(b_resp_data), .resp_yumi_i(resp_yumi),
    .mem_valid_o(b_mem_valid), .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata),
    .mem_wen_o(b_mem_wen), .mem_byte_o(b_mem_byte), .mem_yumi_i(mem_yumi),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_ryumi_o(b_mem_ryumi),
    .owner_o(b_owner), .err_o(b_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid  = 2'b00;
    req_addr   = '0;
    req_wdata  = '0;
    req_wen    = 2'b00;
    req_byte   = 2'b00;
    resp_yumi  = 2'b00;
    mem_yumi   = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    n_reset = 1'b0;
    step();
    step();
    n_reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    n_reset = 1'b0;
    #3;
    n_vec++;
    if ({a_mem_valid, a_req_yumi, a_resp_valid, a_err, a_owner, a_mem_ryumi} !== 8'h00) begin
      n_bad++;
      $display("FAIL rst_ctrl: got %b want 00000000",
               {a_mem_valid, a_req_yumi, a_resp_valid, a_err, a_owner, a_mem_ryumi});
    end
    n_vec++;
    if ({a_mem_addr, a_mem_wdata, a_mem_wen, a_mem_byte, a_resp_data} !== 78'd0) begin
      n_bad++;
      $display("FAIL rst_data: addr %h wdata %h wen %b byte %b rdata %h want all 0",
               a_mem_addr, a_mem_wdata, a_mem_wen, a_mem_byte, a_resp_data);
    end
    step();
    n_reset = 1'b1;
  endtask

  task automatic test_port0_read();
    req_valid = 2'b01; req_addr[0] = 12'h010; req_wen = 2'b00;
    #1;
    n_vec++;
    if (a_mem_valid !== 1'b0) begin
      n_bad++; $display("FAIL rd_grant_cycle_valid: got %b want 0", a_mem_valid);
    end
    step();
    for (int c = 0; c < 2; c++) begin
      #1;
      n_vec++;
      if ({a_mem_valid, a_mem_addr, a_owner, a_req_yumi} !== {1'b1, 12'h010, 1'b0, 2'b00}) begin
        n_bad++;
        $display("FAIL rd_sent_wait: valid %b addr %h owner %b yumi %b want 1 010 0 00",
                 a_mem_valid, a_mem_addr, a_owner, a_req_yumi);
      end
      step();
    end
    mem_yumi = 1'b1;
    #1;
    n_vec++;
    if ({a_req_yumi, a_mem_addr} !== {2'b01, 12'h010}) begin
      n_bad++; $display("FAIL rd_yumi: yumi %b addr %h want 01 010", a_req_yumi, a_mem_addr);
    end
    step();
    mem_yumi = 1'b0; req_valid = 2'b00;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; resp_yumi = 2'b01;
    #1;
    n_vec++;
    if ({a_mem_valid, a_req_yumi, a_resp_valid, a_resp_data, a_mem_ryumi} !==
        {1'b0, 2'b00, 2'b01, 32'hDEADBEEF, 1'b1}) begin
      n_bad++;
      $display("FAIL rd_resp: valid %b yumi %b rvalid %b data %h ryumi %b want 0 00 01 deadbeef 1",
               a_mem_valid, a_req_yumi, a_resp_valid, a_resp_data, a_mem_ryumi);
    end
    step();
    mem_rvalid = 1'b0; resp_yumi = 2'b00;
    #1;
    n_vec++;
    if ({a_mem_valid, a_resp_valid, a_resp_data} !== 35'd0) begin
      n_bad++;
      $display("FAIL rd_done: valid %b rvalid %b data %h want 0 00 0",
               a_mem_valid, a_resp_valid, a_resp_data);
    end
  endtask

  task automatic test_round_robin();
    int rem0, rem1;
    logic [1:0] exp_y;
    do_reset();
    rem0 = 3; rem1 = 3;
    req_valid = 2'b11; req_addr[0] = 12'h100; req_addr[1] = 12'h200;
    mem_yumi = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0000_5555; resp_yumi = 2'b11;
    for (int t = 0; t < 6; t++) begin
      exp_y = (t % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      n_vec++;
      if ({a_mem_valid, a_mem_ryumi, a_resp_valid} !== 4'b0000) begin
        n_bad++;
        $display("FAIL rr_idle_%0d: valid %b ryumi %b rvalid %b want 0 0 00",
                 t, a_mem_valid, a_mem_ryumi, a_resp_valid);
      end
      step();
      #1;
      n_vec++;
      if ({a_owner, a_req_yumi, a_mem_addr} !== {exp_y[1], exp_y, exp_y[1] ? 12'h200 : 12'h100}) begin
        n_bad++;
        $display("FAIL rr_grant_%0d: owner %b yumi %b addr %h want %b %b %h",
                 t, a_owner, a_req_yumi, a_mem_addr, exp_y[1], exp_y,
                 exp_y[1] ? 12'h200 : 12'h100);
      end
      step();
      if (exp_y[1]) rem1--; else rem0--;
      req_valid = {rem1 > 0, rem0 > 0};
      #1;
      n_vec++;
      if (a_resp_valid !== exp_y) begin
        n_bad++; $display("FAIL rr_resp_%0d: got %b want %b", t, a_resp_valid, exp_y);
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_byte_write();
    req_valid = 2'b10; req_addr[1] = 12'hABC; req_wdata[1] = 32'h0000_00A5;
    req_wen = 2'b10; req_byte = 2'b10;
    step();
    mem_yumi = 1'b1;
    #1;
    n_vec++;
    if ({a_mem_wen, a_mem_byte, a_mem_wdata, a_mem_addr, a_owner, a_req_yumi} !==
        {1'b1, 1'b1, 32'h0000_00A5, 12'hABC, 1'b1, 2'b10}) begin
      n_bad++;
      $display("FAIL wr_cmd: wen %b byte %b wdata %h addr %h owner %b yumi %b want 1 1 a5 abc 1 10",
               a_mem_wen, a_mem_byte, a_mem_wdata, a_mem_addr, a_owner, a_req_yumi);
    end
    step();
    idle_inputs();
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222; resp_yumi = 2'b01;
    #1;
    n_vec++;
    if ({a_resp_valid, a_mem_ryumi} !== 3'b100) begin
      n_bad++;
      $display("FAIL wr_wrong_yumi: rvalid %b ryumi %b want 10 0", a_resp_valid, a_mem_ryumi);
    end
    step();
    resp_yumi = 2'b10;
    #1;
    n_vec++;
    if ({a_resp_valid, a_mem_ryumi} !== 3'b101) begin
      n_bad++;
      $display("FAIL wr_owner_yumi: rvalid %b ryumi %b want 10 1", a_resp_valid, a_mem_ryumi);
    end
    step();
    #1;
    n_vec++;
    if ({a_mem_valid, a_resp_valid, a_mem_ryumi} !== 4'b0000) begin
      n_bad++;
      $display("FAIL wr_idle_ignores_rvalid: valid %b rvalid %b ryumi %b want 0 00 0",
               a_mem_valid, a_resp_valid, a_mem_ryumi);
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    req_valid = 2'b01; req_addr[0] = 12'h044;
    step();
    mem_yumi = 1'b1;
    step();
    idle_inputs();
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_vec++;
      if ({a_mem_ryumi, a_resp_valid, a_err, a_resp_data} !== {1'b0, 2'b01, 1'b0, 32'h1234_5678}) begin
        n_bad++;
        $display("FAIL bp_hold_%0d: ryumi %b rvalid %b err %b data %h want 0 01 0 12345678",
                 c, a_mem_ryumi, a_resp_valid, a_err, a_resp_data);
      end
      step();
    end
    resp_yumi = 2'b01;
    #1;
    n_vec++;
    if (a_mem_ryumi !== 1'b1) begin
      n_bad++; $display("FAIL bp_consume: ryumi %b want 1", a_mem_ryumi);
    end
    step();
    idle_inputs();
    #1;
    n_vec++;
    if ({a_err, a_mem_valid, a_resp_valid} !== 4'b0000) begin
      n_bad++;
      $display("FAIL bp_done: err %b valid %b rvalid %b want 0 0 00", a_err, a_mem_valid, a_resp_valid);
    end
  endtask

  task automatic test_hang();
    req_valid = 2'b01; req_addr[0] = 12'h0F0;
    step();
    mem_yumi = 1'b1;
    step();
    idle_inputs();
    for (int k = 1; k <= 16; k++) begin
      step();
      #1;
      if (k == 3) begin
        n_vec++;
        if (a_err !== 1'b0) begin n_bad++; $display("FAIL hang4_early: got %b want 0", a_err); end
      end
      if (k == 4) begin
        n_vec++;
        if (a_err !== 1'b1) begin n_bad++; $display("FAIL hang4_err: got %b want 1", a_err); end
      end
      if (k == 15) begin
        n_vec++;
        if (b_err !== 1'b0) begin n_bad++; $display("FAIL hang16_early: got %b want 0", b_err); end
      end
      if (k == 16) begin
        n_vec++;
        if (b_err !== 1'b1) begin n_bad++; $display("FAIL hang16_err: got %b want 1", b_err); end
      end
    end
    req_valid = 2'b11; mem_yumi = 1'b1; mem_rvalid = 1'b1; resp_yumi = 2'b11;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++;
      if ({b_err, b_mem_valid, b_req_yumi, b_resp_valid, b_mem_ryumi} !== 7'b1000000) begin
        n_bad++;
        $display("FAIL err_stuck_%0d: err %b valid %b yumi %b rvalid %b ryumi %b want 1 0 00 00 0",
                 c, b_err, b_mem_valid, b_req_yumi, b_resp_valid, b_mem_ryumi);
      end
      step();
    end
    idle_inputs();
    n_reset = 1'b0;
    #1;
    n_vec++;
    if ({a_err, b_err} !== 2'b00) begin
      n_bad++; $display("FAIL err_clear: got %b want 00", {a_err, b_err});
    end
    step();
    n_reset = 1'b1;
  endtask

  task automatic test_reset_mid();
    req_valid = 2'b01; req_addr[0] = 12'h333;
    step();
    #1;
    n_vec++;
    if ({a_mem_valid, a_owner} !== 2'b10) begin
      n_bad++; $display("FAIL mid_sent: valid %b owner %b want 1 0", a_mem_valid, a_owner);
    end
    n_reset = 1'b0;
    #1;
    n_vec++;
    if ({a_mem_valid, a_mem_addr} !== {1'b0, 12'h000}) begin
      n_bad++; $display("FAIL mid_async: valid %b addr %h want 0 000", a_mem_valid, a_mem_addr);
    end
    n_reset = 1'b1;
    req_valid = 2'b11; req_addr[1] = 12'h777;
    step();
    #1;
    n_vec++;
    if ({a_mem_valid, a_owner, a_mem_addr} !== {1'b1, 1'b0, 12'h333}) begin
      n_bad++;
      $display("FAIL mid_tie: valid %b owner %b addr %h want 1 0 333", a_mem_valid, a_owner, a_mem_addr);
    end
    idle_inputs();
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    n_reset = 1'b0;
    idle_inputs();
    test_reset();
    test_port0_read();
    test_round_robin();
    test_byte_write();
    test_backpressure();
    test_hang();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: port 0 is the core load/store unit, port 1 is the network loader/debug path.
- Round-robin arbitration with one transaction outstanding at a time.
- Uses the team's valid/yumi handshake (mem_in_s / mem_out_s semantics) on both sides.
- Sequences each transaction as issue, memory acknowledge, then response, and routes the response back to its owner.
- A watchdog flags a hung memory.

Parameters:
- addr_width_p, 12 (data_mem_addr_width_gp), byte address width.
- timeout_cycles_p, 64, max cycles from memory acknowledge to memory response valid before error; legal range 2..255.

Ports:
- clk  in  1  clock, rising edge.
- n_reset  in  1  reset, asynchronous, active-low.
- req_valid_i  in  2  per-port request valid; held stable until req_yumi_o.
- req_addr_i  in  2 x addr_width_p  per-port address.
- req_wdata_i  in  2 x 32  per-port write data.
- req_wen_i  in  2  per-port write enable.
- req_byte_i  in  2  per-port byte_not_word.
- req_yumi_o  out  2  one-cycle pulse: request accepted by memory.
- resp_valid_o  out  2  response valid for owning port.
- resp_data_o  out  32  response read data, shared by both ports.
- resp_yumi_i  in  2  per-port response consume.
- mem_valid_o  out  1  command valid to memory.
- mem_addr_o  out  addr_width_p  latched address.
- mem_wdata_o  out  32  latched write data.
- mem_wen_o  out  1  latched write enable.
- mem_byte_o  out  1  latched byte_not_word.
- mem_yumi_i  in  1  memory accepts command.
- mem_rvalid_i  in  1  memory response valid.
- mem_rdata_i  in  32  memory read data.
- mem_ryumi_o  out  1  arbiter consumes memory response.
- owner_o  out  1  port owning the current transaction.
- err_o  out  1  sticky timeout error.

Behaviour:
- States use dmem_req_state plus an error state: DMEM_IDLE, DMEM_REQ_SENT, DMEM_REQ_ACKED, ERR.
- Reset values:
  - state DMEM_IDLE.
  - all outputs 0, including mem_valid_o, req_yumi_o, resp_valid_o, err_o and owner_o.
  - latched command registers 0.
  - last_grant_r = 1, so port 0 wins the first tie.
- DMEM_IDLE:
  - If any req_valid_i is set: grant one port, latch its addr/wdata/wen/byte, set owner_o, go to DMEM_REQ_SENT.
  - Single valid: grant that port.
  - Both valid: grant !last_grant_r.
  - last_grant_r updates to the granted port.
  - Grant decided in cycle N; mem_valid_o is 1 from cycle N+1, driven from registers.
- DMEM_REQ_SENT:
  - mem_valid_o = 1 and the command is held stable.
  - In a cycle with mem_yumi_i = 1: req_yumi_o[owner] = 1 combinationally in that same cycle, mem_valid_o drops next cycle, watchdog counter clears to 0, go to DMEM_REQ_ACKED.
  - The requester may drop or change its request after the yumi cycle.
  - No timeout applies in this state; memory may stall acceptance indefinitely.
- DMEM_REQ_ACKED:
  - resp_valid_o[owner] = mem_rvalid_i, resp_data_o = mem_rdata_i, mem_ryumi_o = resp_yumi_i[owner]; all combinational pass-through.
  - resp_yumi_i of the non-owner is ignored.
  - Every request, reads and writes alike, gets exactly one memory response. Write response data is don't-care but must still be consumed.
  - When mem_rvalid_i and resp_yumi_i[owner] are both 1: go to DMEM_IDLE. A new grant may be made on the following cycle, giving a minimum of 3 cycles per transaction with no back-to-back overlap.
  - Watchdog counter (8 bits) increments each cycle while mem_rvalid_i = 0.
  - While mem_rvalid_i = 1 the counter holds, so response backpressure does not time out.
  - Counter reaching timeout_cycles_p: go to ERR, err_o = 1.
- ERR:
  - Terminal; exits only via n_reset.
  - No grants; mem_valid_o, req_yumi_o, resp_valid_o and mem_ryumi_o are all 0.
  - err_o stays 1.
- Non-owner port: req_yumi_o and resp_valid_o stay 0 for the whole transaction. Its pending request waits and wins the next arbitration.
- A requester asserting req_valid_i during a busy transaction is not latched until DMEM_IDLE.
- Reset mid-transaction: immediate return to reset values. Any in-flight memory response after reset is the memory's concern; the arbiter ignores mem_rvalid_i in DMEM_IDLE, where mem_ryumi_o = 0.
- resp_data_o = 0 whenever state is not DMEM_REQ_ACKED.

Test Plan:
- Port 0 read, addr 0x010, mem_yumi_i asserted 2 cycles after mem_valid_o, then mem_rvalid_i with 0xDEADBEEF -> req_yumi_o[0] pulses once; resp_valid_o[0] = 1 with 0xDEADBEEF; port 1 outputs stay 0; mem_addr_o = 0x010 throughout DMEM_REQ_SENT.
- Both ports valid from reset, each issuing 3 requests, memory always ready -> grant order 0,1,0,1,0,1; owner_o matches; each transaction takes 3 cycles.
- Port 1 byte write, addr 0xABC, data 0x000000A5, while port 0 idle -> mem_wen_o = 1, mem_byte_o = 1, mem_wdata_o = 0xA5; response consumed only via resp_yumi_i[1].
- Response backpressure: mem_rvalid_i = 1 with resp_yumi_i[0] = 0 for 5 cycles, timeout_cycles_p = 4 -> mem_ryumi_o = 0; state holds; err_o stays 0; completes when resp_yumi_i[0] = 1.
- timeout_cycles_p = 16, memory acknowledges but never responds -> err_o = 1 exactly 16 cycles after the ack cycle; subsequent req_valid_i gets no req_yumi_o; n_reset clears err_o.
- n_reset asserted in DMEM_REQ_SENT with port 0 owner -> mem_valid_o = 0 without waiting for a clock; after release, port 0 wins a tie with port 1.
